ifetch_ctrl: RTL and testbench

- Fetch controller that drives the `pc` register: it reads `Dout` on `PcIn` and writes it through `PcNext`/`PcLdEn`, so it is the read/write partner of that register.
- Issues one instruction-memory read at a time using a req/ack handshake and holds the fetched word for decode using a valid/ready handshake.
- Applies branch/jump redirects from later pipeline stages and squashes any fetch that is in flight when a redirect arrives.

---
 rtl/ifetch_ctrl.sv | 108 ++++++++++
 tb/tb_ifetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives the external pc register, issues one
// memory read at a time and holds the fetched word until decode accepts it.
module ifetch_ctrl #(
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PcIn,
  output logic [31:0] PcNext,
  output logic        PcLdEn,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr
);

  // state | meaning
  // IDLE  | out of reset, no request yet
  // REQ   | read outstanding at req_addr_q
  // HOLD  | fetched word presented to decode
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        squash_q, squash_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        enter_req;

  assign PcNext = Redirect ? RedirectAddr : (PcIn + PC_INC);
  assign PcLdEn = !Reset && (Redirect || (state_q == REQ && IMemAck && !squash_q));

  assign IMemReq    = (state_q == REQ);
  assign IMemAddr   = {req_addr_q[31:2], 2'b00};
  assign Instr      = instr_q;
  assign InstrPc    = instr_pc_q;
  assign InstrValid = instr_valid_q;

  always_comb begin
    state_d       = state_q;
    squash_d      = squash_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    enter_req     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d   = REQ;
        enter_req = 1'b1;
      end
      REQ: begin
        if (IMemAck) begin
          if (!squash_q && !Redirect) begin
            instr_d       = IMemRdata;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end else begin
            // stale data: refetch from the corrected PC
            squash_d  = 1'b0;
            enter_req = 1'b1;
          end
        end else if (Redirect) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (Redirect || InstrReady) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
          enter_req     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_req) req_addr_d = PcLdEn ? PcNext : PcIn;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      squash_q      <= 1'b0;
      req_addr_q    <= 32'd0;
      instr_q       <= NOP_WORD;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      squash_q      <= squash_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a local pc register and hand-driven memory.
module tb_ifetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PcIn;
  logic [31:0] PcNext;
  logic        PcLdEn;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRdata = 32'd0;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectAddr = 32'd0;

  logic [31:0] pc;
  int errors = 0;
  int checks = 0;

  ifetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .PcIn(PcIn), .PcNext(PcNext), .PcLdEn(PcLdEn),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRdata(IMemRdata),
    .Instr(Instr), .InstrPc(InstrPc), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectAddr(RedirectAddr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset) pc <= 32'd0;
    else if (PcLdEn) pc <= PcNext;
  end
  assign PcIn = pc;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in REQ at addr; ends in REQ at addr+4 (InstrReady assumed 1).
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    chk("seq_req", {31'd0, IMemReq}, 32'd1);
    chk("seq_addr", IMemAddr, addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("seq_wait_addr", IMemAddr, addr);
    end
    IMemAck = 1'b1; IMemRdata = data;
    #1;
    chk("seq_ldnext", PcNext, addr + 32'd4);
    tick();
    IMemAck = 1'b0;
    chk("seq_instr", Instr, data);
    chk("seq_instrpc", InstrPc, addr);
    chk("seq_valid", {31'd0, InstrValid}, 32'd1);
    chk("seq_no_overlap", {31'd0, IMemReq}, 32'd0);
    tick();
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_pcld", {31'd0, PcLdEn}, 32'd0);
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_instrpc", InstrPc, 32'h0);
    Reset = 1'b0;
    #1;
    chk("idle_req", {31'd0, IMemReq}, 32'd0);
    tick();
    chk("t1_req", {31'd0, IMemReq}, 32'd1);
    chk("t1_addr", IMemAddr, 32'h0);
    tick();
    IMemAck = 1'b1; IMemRdata = 32'h2002000A;
    #1;
    chk("t1_pcld", {31'd0, PcLdEn}, 32'd1);
    chk("t1_pcnext", PcNext, 32'h4);
    tick();
    IMemAck = 1'b0;
    chk("t1_instr", Instr, 32'h2002000A);
    chk("t1_instrpc", InstrPc, 32'h0);
    chk("t1_valid", {31'd0, InstrValid}, 32'd1);
    chk("t1_pc", pc, 32'h4);

    // reset from HOLD, then three sequential fetches with 3 wait cycles
    Reset = 1'b1;
    tick();
    chk("rst2_valid", {31'd0, InstrValid}, 32'd0);
    Reset = 1'b0;
    tick();
    InstrReady = 1'b1;
    do_fetch(32'h0, 32'hA0000000, 3);
    do_fetch(32'h4, 32'hA0000004, 3);
    do_fetch(32'h8, 32'hA0000008, 3);

    // redirect coincident with ack at 0xC
    chk("t4_addr", IMemAddr, 32'hC);
    Redirect = 1'b1; RedirectAddr = 32'h40; IMemAck = 1'b1; IMemRdata = 32'hDEADBEEF;
    #1;
    chk("t4_pcnext", PcNext, 32'h40);
    chk("t4_pcld", {31'd0, PcLdEn}, 32'd1);
    tick();
    Redirect = 1'b0; IMemAck = 1'b0;
    chk("t4_instr_kept", Instr, 32'hA0000008);
    chk("t4_valid", {31'd0, InstrValid}, 32'd0);
    chk("t4_next_addr", IMemAddr, 32'h40);
    chk("t4_req", {31'd0, IMemReq}, 32'd1);

    // redirect two cycles into request at 0x40, ack later is squashed
    tick(); tick();
    Redirect = 1'b1; RedirectAddr = 32'h100;
    #1;
    chk("t3_pcld", {31'd0, PcLdEn}, 32'd1);
    tick();
    Redirect = 1'b0;
    chk("t3_pc", pc, 32'h100);
    chk("t3_addr_held", IMemAddr, 32'h40);
    chk("t3_valid0", {31'd0, InstrValid}, 32'd0);
    tick();
    IMemAck = 1'b1; IMemRdata = 32'h00000BAD;
    #1;
    chk("t3_squash_noinc", {31'd0, PcLdEn}, 32'd0);
    tick();
    IMemAck = 1'b0;
    chk("t3_valid1", {31'd0, InstrValid}, 32'd0);
    chk("t3_new_addr", IMemAddr, 32'h100);
    chk("t3_req", {31'd0, IMemReq}, 32'd1);
    chk("t3_pc_kept", pc, 32'h100);

    // backpressure in HOLD
    InstrReady = 1'b0; IMemAck = 1'b1; IMemRdata = 32'h11110000;
    #1;
    chk("bp_pcnext", PcNext, 32'h104);
    tick();
    IMemAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_instr", Instr, 32'h11110000);
      chk("bp_valid", {31'd0, InstrValid}, 32'd1);
      chk("bp_req", {31'd0, IMemReq}, 32'd0);
      chk("bp_pc", pc, 32'h104);
      tick();
    end
    InstrReady = 1'b1;
    tick();
    chk("bp_rel_req", {31'd0, IMemReq}, 32'd1);
    chk("bp_rel_addr", IMemAddr, 32'h104);

    // wrap at top of address space
    Redirect = 1'b1; RedirectAddr = 32'hFFFFFFFC; IMemAck = 1'b1; IMemRdata = 32'h0;
    tick();
    Redirect = 1'b0; IMemAck = 1'b0;
    chk("wr_addr", IMemAddr, 32'hFFFFFFFC);
    IMemAck = 1'b1; IMemRdata = 32'h12345678;
    #1;
    chk("wr_pcnext", PcNext, 32'h0);
    tick();
    IMemAck = 1'b0;
    chk("wr_instrpc", InstrPc, 32'hFFFFFFFC);
    chk("wr_instr", Instr, 32'h12345678);
    chk("wr_pc", pc, 32'h0);
    tick();
    chk("wr_req", {31'd0, IMemReq}, 32'd1);
    chk("wr_next_addr", IMemAddr, 32'h0);

    // reset mid-request
    Reset = 1'b1; Redirect = 1'b1; RedirectAddr = 32'h200;
    #1;
    chk("mr_pcld_forced", {31'd0, PcLdEn}, 32'd0);
    tick();
    chk("mr_req", {31'd0, IMemReq}, 32'd0);
    chk("mr_valid", {31'd0, InstrValid}, 32'd0);
    chk("mr_instr", Instr, 32'h0);
    Reset = 1'b0; Redirect = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
